host_bus_master: RTL

Initiator side of the 8-bit 8080-style host bus (ce_x / a0 / wr_x / rd_x / dat) decoded by the S1D13700 host interface. It converts a simple req/ack transaction request into one correctly timed bus cycle, either a write or a read. Reads capture the returned byte. It sits in the FPGA test harness and the system controller, and drives the LCD controller's host port directly.

---
 rtl/host_bm_pkg.sv | 26 ++
 rtl/host_bus_master_if.sv | 30 +++
 rtl/host_bm_cnt.sv | 33 +++
 rtl/host_bus_master.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/host_bm_pkg.sv
// Shared types and constants for the 8080-style host bus master.
// Optional feature macro: HOST_BM_BUSY_POLL_EN (status polling before writes).
package host_bm_pkg;

  localparam int CNT_W         = 4;
  localparam int STAT_BUSY_BIT = 6;

  localparam int T_SETUP_DEF  = 1;
  localparam int T_STROBE_DEF = 2;
  localparam int T_HOLD_DEF   = 1;
  localparam int T_RECOV_DEF  = 1;

  typedef logic [CNT_W-1:0] cnt_t;

`ifdef HOST_BM_BUSY_POLL_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV, POLL_S} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;
`endif

  // Phase counter load value for a phase lasting 'cycles' clocks.
  function automatic cnt_t phase_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/host_bus_master_if.sv
// Request handshake plus 8080-style host bus pins, as one bundle.
// master: the bus initiator (host_bus_master); slave: whatever drives requests
// and models the LCD controller's host port.
interface host_bus_master_if;
  logic       req;
  logic       req_rd;
  logic       req_a0;
  logic [7:0] req_wdata;
  logic       ack;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ce_x;
  logic       a0;
  logic       wr_x;
  logic       rd_x;
  logic [7:0] dat_o;
  logic       dat_oe;
  logic [7:0] dat_i;

  modport master (
    input  req, req_rd, req_a0, req_wdata, dat_i,
    output ack, busy, done, rdata, ce_x, a0, wr_x, rd_x, dat_o, dat_oe
  );

  modport slave (
    output req, req_rd, req_a0, req_wdata, dat_i,
    input  ack, busy, done, rdata, ce_x, a0, wr_x, rd_x, dat_o, dat_oe
  );
endinterface

// File: rtl/host_bm_cnt.sv
// Loadable down-counter with zero flag, used as the bus phase timer.
// Holds at zero until reloaded; exposes its next value so the owner can
// register outputs that depend on where the count lands.
module host_bm_cnt
  import host_bm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  cnt_t load_val,
  output cnt_t count,
  output cnt_t count_next,
  output logic zero
);

  assign zero = (count == '0);

  // Next count: reload, else decrement until zero.
  always_comb begin
    count_next = count;
    if (load)       count_next = load_val;
    else if (!zero) count_next = count - cnt_t'(1);
  end

  // Count register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/host_bus_master.sv
// Host bus master: turns one req/ack request into one timed 8080-style bus
// cycle (write or read) for the S1D13700 host port.
// Optional feature macro: HOST_BM_BUSY_POLL_EN -- writes are preceded by
// status reads repeated until the busy flag (dat_i bit 6) reads 0.
// All bus outputs are registered from the next state, so they change on the
// same edge the FSM enters a phase.
module host_bus_master
  import host_bm_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_RECOV  = T_RECOV_DEF
) (
  input logic               clk,
  input logic               rst,
  host_bus_master_if.master bus
);

  localparam cnt_t LD_SETUP  = phase_load(T_SETUP);
  localparam cnt_t LD_STROBE = phase_load(T_STROBE);
  localparam cnt_t LD_HOLD   = phase_load(T_HOLD);
  localparam cnt_t LD_RECOV  = phase_load(T_RECOV);

  state_t     state, state_nxt;
  logic       cyc_rd, cyc_rd_nxt;
  logic       cyc_a0, cyc_a0_nxt;
  logic [7:0] cyc_wdata, cyc_wdata_nxt;

`ifdef HOST_BM_BUSY_POLL_EN
  logic poll, poll_nxt, poll_busy;
`else
  localparam logic poll     = 1'b0;
  localparam logic poll_nxt = 1'b0;
`endif

  logic cnt_load, cnt_zero;
  cnt_t cnt_load_val, cnt, cnt_nxt;

  logic bus_active_nxt, strobe_nxt, eff_rd_nxt, eff_a0_nxt;
  logic done_nxt, busy_nxt, leave_strobe;

  logic       ce_x_q, a0_q, wr_x_q, rd_x_q, dat_oe_q, busy_q, done_q;
  logic [7:0] dat_o_q, rdata_q;

  // busy is low only in IDLE and in the done cycle, so ack marks an accept.
  assign bus.ack    = bus.req & ~busy_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.ce_x   = ce_x_q;
  assign bus.a0     = a0_q;
  assign bus.wr_x   = wr_x_q;
  assign bus.rd_x   = rd_x_q;
  assign bus.dat_o  = dat_o_q;
  assign bus.dat_oe = dat_oe_q;

  host_bm_cnt u_phase (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .count     (cnt),
    .count_next(cnt_nxt),
    .zero      (cnt_zero)
  );

  // Next-state logic: advance a phase when its timer reaches zero.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt     = state;
    cyc_rd_nxt    = cyc_rd;
    cyc_a0_nxt    = cyc_a0;
    cyc_wdata_nxt = cyc_wdata;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
`ifdef HOST_BM_BUSY_POLL_EN
    poll_nxt      = poll;
`endif
    unique case (state)
      IDLE:   state_nxt = IDLE;
      SETUP:  if (cnt_zero) begin
                state_nxt    = STROBE;
                cnt_load     = 1'b1;
                cnt_load_val = LD_STROBE;
              end
      STROBE: if (cnt_zero) begin
                state_nxt    = HOLD;
                cnt_load     = 1'b1;
                cnt_load_val = LD_HOLD;
              end
      HOLD:   if (cnt_zero) begin
`ifdef HOST_BM_BUSY_POLL_EN
                state_nxt    = poll ? POLL_S : RECOV;
`else
                state_nxt    = RECOV;
`endif
                cnt_load     = 1'b1;
                cnt_load_val = LD_RECOV;
              end
      RECOV:  if (cnt_zero) state_nxt = IDLE;
`ifdef HOST_BM_BUSY_POLL_EN
      // Poll recovery: go round again while busy, else run the real write.
      POLL_S: if (cnt_zero) begin
                state_nxt    = SETUP;
                cnt_load     = 1'b1;
                cnt_load_val = LD_SETUP;
                if (!poll_busy) poll_nxt = 1'b0;
              end
`endif
      default: state_nxt = IDLE;
    endcase

    if (bus.ack) begin
      state_nxt     = SETUP;
      cnt_load      = 1'b1;
      cnt_load_val  = LD_SETUP;
      cyc_rd_nxt    = bus.req_rd;
      cyc_a0_nxt    = bus.req_a0;
      cyc_wdata_nxt = bus.req_wdata;
`ifdef HOST_BM_BUSY_POLL_EN
      poll_nxt      = ~bus.req_rd;
`endif
    end
  end

  // Output decode for the cycle about to start; poll cycles are status reads.
  always_comb begin
    bus_active_nxt = state_nxt inside {SETUP, STROBE, HOLD};
    strobe_nxt     = (state_nxt == STROBE);
    eff_rd_nxt     = cyc_rd_nxt | poll_nxt;
    eff_a0_nxt     = cyc_a0_nxt & ~poll_nxt;
    done_nxt       = (state_nxt == RECOV) && (cnt_nxt == '0);
    busy_nxt       = (state_nxt != IDLE) && !done_nxt;
    leave_strobe   = (state == STROBE) && cnt_zero;
  end

  // State, request latch and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc_rd    <= 1'b0;
      cyc_a0    <= 1'b0;
      cyc_wdata <= 8'h00;
      ce_x_q    <= 1'b1;
      a0_q      <= 1'b0;
      wr_x_q    <= 1'b1;
      rd_x_q    <= 1'b1;
      dat_o_q   <= 8'h00;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state     <= state_nxt;
      cyc_rd    <= cyc_rd_nxt;
      cyc_a0    <= cyc_a0_nxt;
      cyc_wdata <= cyc_wdata_nxt;
      ce_x_q    <= ~bus_active_nxt;
      wr_x_q    <= ~(strobe_nxt & ~eff_rd_nxt);
      rd_x_q    <= ~(strobe_nxt & eff_rd_nxt);
      dat_oe_q  <= bus_active_nxt & ~eff_rd_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      // a0 and write data are set up on SETUP entry and held through HOLD.
      if (state_nxt == SETUP) begin
        a0_q <= eff_a0_nxt;
        if (!eff_rd_nxt) dat_o_q <= cyc_wdata_nxt;
      end
      if (leave_strobe && cyc_rd && !poll) rdata_q <= bus.dat_i;
    end
  end

`ifdef HOST_BM_BUSY_POLL_EN
  // Poll bookkeeping: active flag and the busy bit sampled at strobe end.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll      <= 1'b0;
      poll_busy <= 1'b0;
    end else begin
      poll <= poll_nxt;
      if (leave_strobe && poll) poll_busy <= bus.dat_i[STAT_BUSY_BIT];
    end
  end
`endif

endmodule
